// File: rtl/ras_checkpoint_stack_super.sv
// Return-address stack for a superscalar fetch stage.
// Picks the first call/return lane of a fetch group, predicts the return
// target with zero latency, updates a circular stack, and exposes a
// {tos,count} checkpoint that can be restored on misprediction recovery.
module ras_checkpoint_stack_super #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 5,
   parameter int PTR_W       = $clog2(DEPTH),
   parameter int LANE_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              fetch_valid_i,
   input  logic                              fetch_ready_i,
   input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] pc_i,
   input  logic [FETCH_WIDTH-1:0]            is_call_i,
   input  logic [FETCH_WIDTH-1:0]            is_return_i,
   input  logic                              restore_en_i,
   input  logic [PTR_W-1:0]                  restore_tos_i,
   input  logic [PTR_W:0]                    restore_count_i,
   output logic [PTR_W-1:0]                  checkpoint_tos_o,
   output logic [PTR_W:0]                    checkpoint_count_o,
   output logic                              pred_valid_o,
   output logic [ADDR_WIDTH-1:0]             pred_target_o,
   output logic [LANE_W-1:0]                 pred_lane_o,
   output logic                              overflow_o,
   output logic                              underflow_o
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_stack [DEPTH];
   logic [PTR_W-1:0]      r_tos;
   logic [CNT_W-1:0]      r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_found;
   logic [LANE_W-1:0]     w_sel;
   logic                  w_sel_call;
   logic                  w_sel_ret;
   logic [ADDR_WIDTH-1:0] w_sel_pc;
   logic [ADDR_WIDTH-1:0] w_ra;
   logic [PTR_W-1:0]      w_tos_inc;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_do_update;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_replace;
   logic                  w_overflow;
   logic                  w_underflow;

   // Priority-select the lowest lane flagged as call or return.
   always_comb begin
      w_found    = 1'b0;
      w_sel      = '0;
      w_sel_call = 1'b0;
      w_sel_ret  = 1'b0;
      w_sel_pc   = '0;
      for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
         if (!w_found && (is_call_i[l] || is_return_i[l])) begin
            w_found    = 1'b1;
            w_sel      = LANE_W'(l);
            w_sel_call = is_call_i[l];
            w_sel_ret  = is_return_i[l];
            w_sel_pc   = pc_i[l*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Decode the stack operation for this cycle; a call+return on an empty
   // stack degrades to a plain push that also reports underflow.
   always_comb begin
      w_ra        = w_sel_pc + ADDR_WIDTH'(4);
      w_tos_inc   = r_tos + PTR_W'(1);
      w_empty     = (r_count == '0);
      w_full      = (r_count == FULL);
      w_do_update = fetch_valid_i & fetch_ready_i & ~restore_en_i & w_found;
      w_push      = w_do_update & w_sel_call & (~w_sel_ret | w_empty);
      w_pop       = w_do_update & w_sel_ret & ~w_sel_call & ~w_empty;
      w_replace   = w_do_update & w_sel_call & w_sel_ret & ~w_empty;
      w_overflow  = w_push & w_full;
      w_underflow = w_do_update & w_sel_ret & w_empty;
   end

   // Zero-latency prediction from the registered top of stack.
   always_comb begin
      pred_valid_o  = fetch_valid_i & w_found & w_sel_ret & ~w_empty & ~restore_en_i;
      pred_target_o = pred_valid_o ? r_stack[r_tos] : '0;
      pred_lane_o   = (reset & fetch_valid_i & w_found) ? w_sel : '0;
   end

   // Stack storage: push writes above TOS, call+return replaces TOS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_stack[i] <= '0;
         end
      end else if (w_push) begin
         r_stack[w_tos_inc] <= w_ra;
      end else if (w_replace) begin
         r_stack[r_tos] <= w_ra;
      end
   end

   // TOS/occupancy update with restore taking priority; pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tos       <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_overflow;
         r_underflow <= w_underflow;
         if (restore_en_i) begin
            r_tos   <= restore_tos_i;
            r_count <= (restore_count_i > FULL) ? FULL : restore_count_i;
         end else if (w_push) begin
            r_tos <= w_tos_inc;
            if (!w_full) begin
               r_count <= r_count + CNT_W'(1);
            end
         end else if (w_pop) begin
            r_tos   <= r_tos - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign checkpoint_tos_o   = r_tos;
   assign checkpoint_count_o = r_count;
   assign overflow_o         = r_overflow;
   assign underflow_o        = r_underflow;

endmodule

// File: tb/tb_ras_checkpoint_stack_super.sv
// Self-checking bench for ras_checkpoint_stack_super: directed scenarios
// followed by randomized fetch groups, all compared against a behavioural
// stack model kept here.
module tb_ras_checkpoint_stack_super;

   localparam int AW     = 32;
   localparam int DEPTH  = 8;
   localparam int FW     = 5;
   localparam int PTR_W  = 3;
   localparam int LANE_W = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 fetch_valid_i;
   logic                 fetch_ready_i;
   logic [FW*AW-1:0]     pc_i;
   logic [FW-1:0]        is_call_i;
   logic [FW-1:0]        is_return_i;
   logic                 restore_en_i;
   logic [PTR_W-1:0]     restore_tos_i;
   logic [PTR_W:0]       restore_count_i;
   logic [PTR_W-1:0]     checkpoint_tos_o;
   logic [PTR_W:0]       checkpoint_count_o;
   logic                 pred_valid_o;
   logic [AW-1:0]        pred_target_o;
   logic [LANE_W-1:0]    pred_lane_o;
   logic                 overflow_o;
   logic                 underflow_o;

   ras_checkpoint_stack_super #(
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .FETCH_WIDTH(FW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .fetch_valid_i     (fetch_valid_i),
      .fetch_ready_i     (fetch_ready_i),
      .pc_i              (pc_i),
      .is_call_i         (is_call_i),
      .is_return_i       (is_return_i),
      .restore_en_i      (restore_en_i),
      .restore_tos_i     (restore_tos_i),
      .restore_count_i   (restore_count_i),
      .checkpoint_tos_o  (checkpoint_tos_o),
      .checkpoint_count_o(checkpoint_count_o),
      .pred_valid_o      (pred_valid_o),
      .pred_target_o     (pred_target_o),
      .pred_lane_o       (pred_lane_o),
      .overflow_o        (overflow_o),
      .underflow_o       (underflow_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [AW-1:0] m_stack [DEPTH];
   int            m_tos;
   int            m_count;
   bit            m_ovf;
   bit            m_udf;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
      m_tos = 0; m_count = 0; m_ovf = 0; m_udf = 0;
   endtask

   task automatic clear_inputs();
      fetch_valid_i   = 1'b0;
      fetch_ready_i   = 1'b1;
      pc_i            = '0;
      is_call_i       = '0;
      is_return_i     = '0;
      restore_en_i    = 1'b0;
      restore_tos_i   = '0;
      restore_count_i = '0;
   endtask

   task automatic set_pc(input int lane, input logic [AW-1:0] val);
      pc_i[lane*AW +: AW] = val;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic do_cycle();
      bit            found, c, r, pv;
      int            sel;
      logic [AW-1:0] pc, ra, tgt;
      found = 0; sel = 0; c = 0; r = 0; pc = '0;
      for (int l = 0; l < FW; l++) begin
         if (!found && (is_call_i[l] || is_return_i[l])) begin
            found = 1; sel = l; c = is_call_i[l]; r = is_return_i[l];
            pc = pc_i[l*AW +: AW];
         end
      end
      pv  = fetch_valid_i && found && r && (m_count > 0) && !restore_en_i;
      tgt = pv ? m_stack[m_tos] : '0;
      @(negedge clk);
      check_eq("ckpt_tos",   64'(checkpoint_tos_o),   64'(m_tos));
      check_eq("ckpt_count", 64'(checkpoint_count_o), 64'(m_count));
      check_eq("pred_valid", 64'(pred_valid_o),       64'(pv));
      check_eq("pred_target",64'(pred_target_o),      64'(tgt));
      check_eq("pred_lane",  64'(pred_lane_o),        64'((fetch_valid_i && found) ? sel : 0));
      check_eq("overflow",   64'(overflow_o),         64'(m_ovf));
      check_eq("underflow",  64'(underflow_o),        64'(m_udf));
      // next-state from the behavioural rules
      ra = pc + 32'd4;
      m_ovf = 0; m_udf = 0;
      if (restore_en_i) begin
         m_tos   = int'(restore_tos_i);
         m_count = (int'(restore_count_i) > DEPTH) ? DEPTH : int'(restore_count_i);
      end else if (fetch_valid_i && fetch_ready_i && found) begin
         if (c && (!r || m_count == 0)) begin
            m_ovf   = (m_count == DEPTH);
            m_udf   = r;
            m_tos   = (m_tos + 1) % DEPTH;
            m_stack[m_tos] = ra;
            m_count = (m_count + 1 > DEPTH) ? DEPTH : m_count + 1;
         end else if (c && r) begin
            m_stack[m_tos] = ra;
         end else if (m_count > 0) begin
            m_tos   = (m_tos + DEPTH - 1) % DEPTH;
            m_count = m_count - 1;
         end else begin
            m_udf = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic call_at(input int lane, input logic [AW-1:0] pc);
      clear_inputs();
      fetch_valid_i = 1'b1;
      is_call_i[lane] = 1'b1;
      set_pc(lane, pc);
      do_cycle();
   endtask

   task automatic ret_at(input int lane);
      clear_inputs();
      fetch_valid_i = 1'b1;
      is_return_i[lane] = 1'b1;
      do_cycle();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      reset = 1'b0;
      // outputs must be quiet in reset even with an active return group
      fetch_valid_i = 1'b1;
      is_return_i[2] = 1'b1;
      set_pc(2, 32'h40);
      @(negedge clk);
      check_eq("rst_pred_valid", 64'(pred_valid_o), 64'd0);
      check_eq("rst_pred_lane",  64'(pred_lane_o),  64'd0);
      check_eq("rst_pred_tgt",   64'(pred_target_o),64'd0);
      check_eq("rst_tos",        64'(checkpoint_tos_o), 64'd0);
      check_eq("rst_count",      64'(checkpoint_count_o), 64'd0);
      check_eq("rst_ovf_udf",    64'({overflow_o, underflow_o}), 64'd0);
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: call then return on lane 2
      call_at(0, 32'h100);
      check_eq("s1_tos", 64'(checkpoint_tos_o), 64'd1);
      check_eq("s1_count", 64'(checkpoint_count_o), 64'd1);
      ret_at(2);
      check_eq("s1_pop_count", 64'(checkpoint_count_o), 64'd0);

      // 2: return on lane 1 wins over call on lane 3
      call_at(4, 32'h300);
      clear_inputs();
      fetch_valid_i = 1'b1;
      is_return_i[1] = 1'b1;
      is_call_i[3] = 1'b1;
      set_pc(3, 32'h500);
      do_cycle();
      check_eq("s2_count", 64'(checkpoint_count_o), 64'd0);

      // 3: overflow by DEPTH+1 calls, then DEPTH returns
      for (int i = 0; i <= DEPTH; i++) call_at(0, 32'(i * 16));
      check_eq("s3_sat", 64'(checkpoint_count_o), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) ret_at(0);

      // 4: return on empty stack, then an idle cycle to see the pulse
      ret_at(3);
      clear_inputs();
      do_cycle();

      // 5: checkpoint, 3 calls, restore with simultaneous call
      call_at(0, 32'h1000);
      call_at(0, 32'h1010);
      for (int i = 0; i < 3; i++) call_at(1, 32'(32'h2000 + i * 8));
      clear_inputs();
      fetch_valid_i   = 1'b1;
      is_call_i[0]    = 1'b1;
      set_pc(0, 32'h3000);
      restore_en_i    = 1'b1;
      restore_tos_i   = 3'(m_tos + DEPTH - 3);
      restore_count_i = 4'd2;
      do_cycle();
      check_eq("s5_count", 64'(checkpoint_count_o), 64'd2);

      // 6: call+return with count 3, then a 2-cycle stall
      call_at(2, 32'h1020);
      clear_inputs();
      fetch_valid_i = 1'b1;
      is_call_i[0] = 1'b1;
      is_return_i[0] = 1'b1;
      set_pc(0, 32'h200);
      do_cycle();
      check_eq("s6_count", 64'(checkpoint_count_o), 64'd3);
      fetch_ready_i = 1'b0;
      do_cycle();
      do_cycle();
      check_eq("s6_stall_count", 64'(checkpoint_count_o), 64'd3);

      // randomized fetch groups
      for (int n = 0; n < 2000; n++) begin
         clear_inputs();
         fetch_valid_i = ($urandom % 8) != 0;
         fetch_ready_i = ($urandom % 4) != 0;
         for (int l = 0; l < FW; l++) begin
            set_pc(l, $urandom & 32'hFFFF_FFFC);
            is_call_i[l]   = ($urandom % 6) == 0;
            is_return_i[l] = ($urandom % 6) == 0;
         end
         restore_en_i    = ($urandom % 12) == 0;
         restore_tos_i   = 3'($urandom);
         restore_count_i = 4'($urandom_range(0, 15));
         do_cycle();
      end

      // asynchronous reset clears state without a clock edge
      call_at(0, 32'h700);
      clear_inputs();
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst_count", 64'(checkpoint_count_o), 64'd0);
      check_eq("async_rst_tos",   64'(checkpoint_tos_o),   64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
